bird_motion: RTL and testbench
==============================

# bird_motion

Parametrised bird physics engine for the Flappy Bird datapath, replacing the fixed-step bird position generator. It holds a signed vertical velocity and integrates gravity, flap impulse and terminal velocity once per frame tick. It clamps the bird to configurable screen bounds and runs a game-phase state machine (idle, play, dying, dead). Its inputs come from the frame-tick generator, the debounced flap key and the collision checker; its outputs feed the renderer and the game checker.

## Interface
- W, 11: width of coordinate outputs.
- VW, 8: width of signed velocity register.
- X_POS, 125: constant bird x coordinate.
- Y_START, 360: y on reset and on every (re)start.
- Y_MIN, 0: ceiling y.
- Y_MAX, 700: floor y (bird top-left at floor).
- GRAVITY, 1: velocity increment per tick (unsigned).
- FLAP_VEL, -12: velocity loaded on flap (signed).
- V_MAX, 8: terminal downward velocity (positive).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- move  in  1  one-clk frame-tick strobe; physics steps only on this.
- flap  in  1  one-clk debounced flap pulse.
- start  in  1  one-clk pulse; begins or restarts a game.
- collide  in  1  level; pipe collision from the game checker.
- bird_x  out  W  always X_POS.
- bird_y  out  W  current bird y.
- bird_vy  out  VW  current signed velocity (two's complement).
- phase  out  2  0 IDLE, 1 PLAY, 2 DYING, 3 DEAD.
- hit_floor  out  1  one-clk pulse when the floor is reached.

## Operation
- Reset (RESET_N low, asynchronous) sets:
  - phase=IDLE, bird_y=Y_START, bird_vy=0.
  - flap_pend=0, hit_floor=0.
- flap_pend latches any flap pulse seen in PLAY. It clears on the next move tick.
- IDLE:
  - y and vy are held.
  - start or flap → PLAY, with y=Y_START and vy=0.
  - A flap that causes the entry also sets flap_pend.
- PLAY, on each move tick:
  - Velocity: if flap_pend or flap is high, vy=FLAP_VEL; else vy=min(vy+GRAVITY, V_MAX).
  - Position: y_new = y + vy_new, computed signed at W+2 bits.
  - y_new < Y_MIN → y=Y_MIN, vy=0; phase stays PLAY.
  - y_new ≥ Y_MAX → y=Y_MAX, vy=0, hit_floor pulses, → DEAD.
  - Otherwise y=y_new.
- PLAY, collide high on any clk (tick or not) → DYING; vy is unchanged and flap_pend is cleared.
- DYING:
  - flap is ignored.
  - Each tick applies gravity and terminal velocity only.
  - On reaching Y_MAX: clamp, hit_floor pulse, → DEAD.
- DEAD:
  - y and vy are held; flap is ignored.
  - start → PLAY with y=Y_START, vy=0.
- start in PLAY or DYING is ignored.
- collide in IDLE or DEAD is ignored.
- Velocity saturates at VW bits. FLAP_VEL and V_MAX must fit VW signed; the implementation must not wrap.

## Timing
- All outputs are registered. A move tick at clk edge N gives new bird_y, bird_vy and phase visible after edge N.
- Latency from move to output: 1 clk.
- flap and move in the same clk: the flap applies to that tick.
- flap in a non-tick clk: applied at the next tick. Multiple flaps between ticks count as one.
- collide and move in the same PLAY clk: the phase goes to DYING and that tick applies gravity only (no flap).
- Floor reached and collide in the same clk: → DEAD, with hit_floor pulsed.
- start and move in the same clk in IDLE/DEAD: the restart wins; y=Y_START, vy=0, and no physics step.
- hit_floor is high for exactly one clk, on the cycle after the tick that reached the floor.
- RESET_N assertion mid-game returns all state to reset values immediately, without waiting for clk. Deassertion is synchronised externally.

## Test plan
- Reset, then 10 move ticks with no input → phase=0, bird_y=360, bird_vy=0 throughout; bird_x=125.
- start, then 5 ticks → vy=1,2,3,4,5 and bird_y=361,363,366,370,375.
- Continue ticking to terminal velocity → vy saturates at 8 and y steps by 8 per tick. The floor is reached and bird_y=700, a single hit_floor pulse occurs and phase=3. Further ticks and flaps leave bird_y at 700.
- From y=360, vy=0 in PLAY, flap concurrent with a tick → vy=-12, y=348. A flap 3 clk before the next tick, with no repeat → that tick gives vy=-12, y=336. Two flaps between ticks → a single -12 load.
- Flap repeatedly near the top from y=10 → y clamps to 0 with vy=0, phase stays 1, and the next tick without a flap gives vy=1, y=1.
- collide in PLAY with vy=-12 → phase=2. Flaps are ignored and vy rises by 1 per tick to the floor, then phase=3. start → phase=1, y=360, vy=0. Pulling RESET_N low mid-fall → phase=0 and y=360 before the next clk edge.

Source files
------------

// File: rtl/bird_motion.sv
// bird_motion: per-frame bird physics and game-phase FSM.
// In: clk, RESET_N, move, flap, start, collide. Out: bird_x/y/vy, phase, hit_floor.
module bird_motion #(
  parameter int W        = 11,
  parameter int VW       = 8,
  parameter int X_POS    = 125,
  parameter int Y_START  = 360,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 700,
  parameter int GRAVITY  = 1,
  parameter int FLAP_VEL = -12,
  parameter int V_MAX    = 8
) (
  input  logic                 clk,
  input  logic                 RESET_N,
  input  logic                 move,
  input  logic                 flap,
  input  logic                 start,
  input  logic                 collide,
  output logic [W-1:0]         bird_x,
  output logic [W-1:0]         bird_y,
  output logic signed [VW-1:0] bird_vy,
  output logic [1:0]           phase,
  output logic                 hit_floor
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_DYING = 2'd2;
  localparam logic [1:0] S_DEAD  = 2'd3;

  localparam logic [W-1:0] X_W = W'(X_POS);
  localparam logic [W-1:0] YS_W = W'(Y_START);
  localparam logic [W-1:0] YMIN_W = W'(Y_MIN);
  localparam logic [W-1:0] YMAX_W = W'(Y_MAX);
  localparam logic signed [W+1:0] YMIN_S = (W+2)'(Y_MIN);
  localparam logic signed [W+1:0] YMAX_S = (W+2)'(Y_MAX);
  localparam logic signed [VW:0] GRAV_S = (VW+1)'(GRAVITY);
  localparam logic signed [VW:0] VMAX_S = (VW+1)'(V_MAX);
  localparam logic signed [VW-1:0] VMAX_V = VW'(V_MAX);
  localparam logic signed [VW-1:0] FLAP_V = VW'(FLAP_VEL);

  logic [1:0]           phase_q, phase_d;
  logic [W-1:0]         y_q, y_d;
  logic signed [VW-1:0] vy_q, vy_d;
  logic                 pend_q, pend_d;
  logic                 hit_q, hit_d;

  logic                 flap_eff;
  logic signed [VW:0]   vy_sum;
  logic signed [VW-1:0] vy_grav;
  logic signed [VW-1:0] vy_step;
  logic signed [W+1:0]  y_new;
  logic                 at_ceil;
  logic                 at_floor;

  // Flap only counts while playing and not being knocked out this clk.
  assign flap_eff = (phase_q == S_PLAY) && !collide
                  && (pend_q || flap);

  // One extra bit so vy + g cannot wrap before the terminal clamp.
  assign vy_sum  = {vy_q[VW-1], vy_q} + GRAV_S;
  assign vy_grav = (vy_sum > VMAX_S) ? VMAX_V
                                     : vy_sum[VW-1:0];
  assign vy_step = flap_eff ? FLAP_V : vy_grav;

  assign y_new = $signed({2'b00, y_q})
               + {{(W+2-VW){vy_step[VW-1]}}, vy_step};
  assign at_ceil  = y_new < YMIN_S;
  assign at_floor = y_new >= YMAX_S;

  always_comb begin
    phase_d = phase_q;
    y_d     = y_q;
    vy_d    = vy_q;
    pend_d  = pend_q;
    hit_d   = 1'b0;
    unique case (phase_q)
      S_IDLE: begin
        if (start || flap) begin
          phase_d = S_PLAY;
          y_d     = YS_W;
          vy_d    = '0;
          pend_d  = flap;
        end
      end
      S_PLAY, S_DYING: begin
        if (move) begin
          pend_d = 1'b0;
          vy_d   = vy_step;
          if (phase_q == S_PLAY && collide)
            phase_d = S_DYING;
          if (at_ceil) begin
            y_d  = YMIN_W;
            vy_d = '0;
          end else if (at_floor) begin
            y_d     = YMAX_W;
            vy_d    = '0;
            hit_d   = 1'b1;
            phase_d = S_DEAD;
          end else begin
            y_d = y_new[W-1:0];
          end
        end else if (phase_q == S_PLAY) begin
          if (collide) begin
            phase_d = S_DYING;
            pend_d  = 1'b0;
          end else if (flap) begin
            pend_d = 1'b1;
          end
        end
      end
      S_DEAD: begin
        if (start) begin
          phase_d = S_PLAY;
          y_d     = YS_W;
          vy_d    = '0;
          pend_d  = 1'b0;
        end
      end
      default: phase_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      phase_q <= S_IDLE;
      y_q     <= YS_W;
      vy_q    <= '0;
      pend_q  <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      y_q     <= y_d;
      vy_q    <= vy_d;
      pend_q  <= pend_d;
      hit_q   <= hit_d;
    end
  end

  assign bird_x    = X_W;
  assign bird_y    = y_q;
  assign bird_vy   = vy_q;
  assign phase     = phase_q;
  assign hit_floor = hit_q;

endmodule

// File: tb/tb_bird_motion.sv
// tb_bird_motion: directed stimulus for bird_motion,
// checked every clk against an integer game model.
module tb_bird_motion;

  logic        clk = 1'b0;
  logic        RESET_N = 1'b0;
  logic        move = 1'b0;
  logic        flap = 1'b0;
  logic        start = 1'b0;
  logic        collide = 1'b0;
  logic [10:0] bird_x;
  logic [10:0] bird_y;
  logic [7:0]  bird_vy;
  logic [1:0]  phase;
  logic        hit_floor;

  int n_cmp = 0;
  int n_bad = 0;

  bird_motion dut (
    .clk(clk), .RESET_N(RESET_N),
    .move(move), .flap(flap),
    .start(start), .collide(collide),
    .bird_x(bird_x), .bird_y(bird_y),
    .bird_vy(bird_vy), .phase(phase),
    .hit_floor(hit_floor)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // Game model: phase 0 idle, 1 play, 2 dying, 3 dead.
  typedef struct {
    int ph;
    int y;
    int vy;
    bit pend;
    bit hit;
  } ms_t;

  function automatic ms_t nxt(input ms_t s, input bit mv,
                              input bit fl, input bit st,
                              input bit co);
    ms_t n;
    bit  f;
    int  ny;
    n = s;
    n.hit = 0;
    if ((s.ph == 0 && (st || fl)) || (s.ph == 3 && st)) begin
      n.ph = 1; n.y = 360; n.vy = 0;
      n.pend = (s.ph == 0) && fl;
      return n;
    end
    if (s.ph == 1 && !mv) begin
      if (co) begin n.ph = 2; n.pend = 0; end
      else if (fl) n.pend = 1;
      return n;
    end
    if ((s.ph == 1 || s.ph == 2) && mv) begin
      f = (s.ph == 1) && !co && (s.pend || fl);
      n.vy = f ? -12 : ((s.vy + 1 > 8) ? 8 : s.vy + 1);
      ny = s.y + n.vy;
      n.pend = 0;
      if (s.ph == 1 && co) n.ph = 2;
      if (ny < 0) begin
        n.y = 0; n.vy = 0;
      end else if (ny >= 700) begin
        n.y = 700; n.vy = 0; n.hit = 1; n.ph = 3;
      end else begin
        n.y = ny;
      end
    end
    return n;
  endfunction

  ms_t m = '{0, 360, 0, 1'b0, 1'b0};

  always @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) m <= '{0, 360, 0, 1'b0, 1'b0};
    else m <= nxt(m, move, flap, start, collide);
  end

  always @(posedge clk) begin
    #1;
    chk("m_phase", int'(phase), m.ph);
    chk("m_y", int'(bird_y), m.y);
    chk("m_vy", int'($signed(bird_vy)), m.vy);
    chk("m_hit", int'(hit_floor), int'(m.hit));
    chk("m_x", int'(bird_x), 125);
  end

  task automatic step(input bit mv, input bit fl,
                      input bit st, input bit co);
    @(negedge clk);
    move = mv; flap = fl; start = st; collide = co;
    @(posedge clk);
    #2;
  endtask

  task automatic expect3(input string nm, input int ph,
                         input int y, input int vy);
    chk({nm, "_phase"}, int'(phase), ph);
    chk({nm, "_y"}, int'(bird_y), y);
    chk({nm, "_vy"}, int'($signed(bird_vy)), vy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int vys[5];
    int ys[5];
    int pulses;
    vys = '{1, 2, 3, 4, 5};
    ys  = '{361, 363, 366, 370, 375};

    repeat (2) @(posedge clk);
    #1 expect3("rst", 0, 360, 0);
    chk("rst_hit", int'(hit_floor), 0);
    @(negedge clk) RESET_N = 1'b1;

    repeat (10) step(1, 0, 0, 0);
    expect3("idle", 0, 360, 0);
    chk("idle_x", int'(bird_x), 125);

    step(0, 0, 1, 0);
    expect3("start", 1, 360, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0);
      expect3("grav", 1, ys[i], vys[i]);
    end

    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      step(1, 0, 0, 0);
      if (hit_floor) pulses++;
    end
    chk("floor_pulses", pulses, 1);
    expect3("floor", 3, 700, 0);
    repeat (3) step(1, 1, 0, 0);
    expect3("dead_hold", 3, 700, 0);

    step(0, 0, 1, 0);
    expect3("restart", 1, 360, 0);
    step(1, 1, 0, 0);
    expect3("flap_tick", 1, 348, -12);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    expect3("flap_pend", 1, 336, -12);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    expect3("flap_twice", 1, 324, -12);
    step(1, 0, 0, 0);
    expect3("flap_once", 1, 313, -11);

    for (int i = 0; i < 40 && bird_y != 0; i++)
      step(1, 1, 0, 0);
    expect3("ceil", 1, 0, 0);
    step(1, 0, 0, 0);
    expect3("ceil_next", 1, 1, 1);

    repeat (20) step(1, 0, 0, 0);
    expect3("fall20", 1, 140, 8);
    step(1, 1, 0, 0);
    expect3("flap2", 1, 128, -12);
    step(0, 0, 0, 1);
    expect3("collide", 2, 128, -12);
    step(1, 1, 0, 0);
    expect3("dying_noflap", 2, 117, -11);
    for (int i = 0; i < 200 && phase != 2'd3; i++)
      step(1, 1, 0, 0);
    expect3("dying_floor", 3, 700, 0);
    step(1, 0, 1, 0);
    expect3("restart_mv", 1, 360, 0);

    step(1, 1, 0, 1);
    expect3("col_tick", 2, 361, 1);
    repeat (3) step(1, 0, 0, 0);
    expect3("col_fall", 2, 370, 4);
    step(0, 0, 0, 0);
    @(posedge clk);
    #3 RESET_N = 1'b0;
    #1 expect3("async_rst", 0, 360, 0);
    @(negedge clk) RESET_N = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
